lsu_req_master: RTL and testbench

Load/store request initiator between the execute stage and the data memory. It accepts one word-aligned load or store from EX and drives it across a valid/ready request channel. For loads it waits on the response channel and hands the returned word to write-back. While an access is outstanding it stalls the pipeline.

---
 rtl/lsu_req_master.sv | 163 ++++++++++++++++
 tb/tb_lsu_req_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_req_master.sv
// lsu_req_master: load/store request initiator between EX and data memory.
// Takes one word-aligned load or store from EX and drives it across a
// valid/ready request channel. Loads then wait for the response channel and
// the returned word is handed to write-back. While an access is in flight
// the front of the pipeline is stalled.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   defined   - WAIT aborts with op_err after TIMEOUT cycles without response
//   undefined - WAIT holds until mem_rsp_valid arrives
module lsu_req_master #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA          = 32,
  parameter int TIMEOUT       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  input  logic                     ex_is_load,
  input  logic                     ex_is_store,
  input  logic [ADDRESS_WIDTH-1:0] ex_addr,
  input  logic [DATA-1:0]          ex_wdata,
  input  logic [4:0]               ex_rd,
  output logic                     stall,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
  output logic [DATA-1:0]          mem_req_wdata,
  input  logic                     mem_rsp_valid,
  input  logic [DATA-1:0]          mem_rsp_rdata,
  output logic                     wb_valid,
  output logic [4:0]               wb_rd,
  output logic [DATA-1:0]          wb_data,
  output logic                     op_done,
  output logic                     op_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                   state_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA-1:0]          wdata_q;
  logic [DATA-1:0]          rdata_q;
  logic [4:0]               rd_q;
  logic                     we_q;
  logic                     req_valid_q;
  logic                     wb_valid_q;
  logic                     op_done_q;
  logic                     op_err_q;
  logic                     mem_op_s;

`ifdef LSU_TIMEOUT_EN
  // Last WAIT count before the access is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]               cnt_q;
`endif

  assign mem_op_s = ex_valid & (ex_is_load | ex_is_store);

  // Stall must react in the accept cycle itself, so it is decoded from the
  // live EX inputs while idle; in DONE the pipeline is released.
  assign stall = ((state_q == S_IDLE) & mem_op_s)
               | (state_q == S_REQ)
               | (state_q == S_WAIT);

  assign mem_req_valid = req_valid_q;
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = rd_q;
  assign wb_data       = rdata_q;
  assign op_done       = op_done_q;
  assign op_err        = op_err_q;

  // Access FSM; retire pulses are registered alongside the DONE transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rd_q        <= 5'd0;
      we_q        <= 1'b0;
      req_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      op_done_q   <= 1'b0;
      op_err_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
      op_done_q  <= 1'b0;
      op_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_op_s) begin
            addr_q  <= ex_addr;
            wdata_q <= ex_wdata;
            rd_q    <= ex_rd;
            we_q    <= ex_is_store;
            if (ex_addr[1:0] != 2'b00) begin
              // Misaligned: retire with error, never touch memory.
              state_q   <= S_DONE;
              op_done_q <= 1'b1;
              op_err_q  <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            if (we_q) begin
              // Stores are posted: no response is awaited.
              state_q   <= S_DONE;
              op_done_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
`ifdef LSU_TIMEOUT_EN
              cnt_q   <= 8'd0;
`endif
            end
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            rdata_q    <= mem_rsp_rdata;
            state_q    <= S_DONE;
            op_done_q  <= 1'b1;
            wb_valid_q <= 1'b1;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            state_q   <= S_DONE;
            op_done_q <= 1'b1;
            op_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        S_DONE: begin
          // EX still presents the retired instruction here; ignore it.
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_req_master.sv
// Directed self-checking bench for lsu_req_master (TIMEOUT=4).
module tb_lsu_req_master;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        op_done;
  logic        op_err;

  int total;
  int bad;

  lsu_req_master #(
    .ADDRESS_WIDTH(32),
    .DATA(32),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ex_valid(ex_valid),
    .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store),
    .ex_addr(ex_addr),
    .ex_wdata(ex_wdata),
    .ex_rd(ex_rd),
    .stall(stall),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .op_done(op_done),
    .op_err(op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to the next cycle: just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    check({tag, ".stall"}, {63'd0, stall}, 64'd0);
    check({tag, ".req_valid"}, {63'd0, mem_req_valid}, 64'd0);
    check({tag, ".req_we"}, {63'd0, mem_req_we}, 64'd0);
    check({tag, ".req_addr"}, {32'd0, mem_req_addr}, 64'd0);
    check({tag, ".req_wdata"}, {32'd0, mem_req_wdata}, 64'd0);
    check({tag, ".wb_valid"}, {63'd0, wb_valid}, 64'd0);
    check({tag, ".wb_rd"}, {59'd0, wb_rd}, 64'd0);
    check({tag, ".wb_data"}, {32'd0, wb_data}, 64'd0);
    check({tag, ".op_done"}, {63'd0, op_done}, 64'd0);
    check({tag, ".op_err"}, {63'd0, op_err}, 64'd0);
  endtask

  // Best-case load starting in the current cycle (cycle 0); returns in cycle 3.
  task automatic run_load(input string tag, input logic [31:0] a, input logic [4:0] r,
                          input logic [31:0] d);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0;
    ex_addr = a; ex_rd = r; ex_wdata = 32'h0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    @(negedge clk);
    check({tag, ".c0.stall"}, {63'd0, stall}, 64'd1);
    check({tag, ".c0.req_valid"}, {63'd0, mem_req_valid}, 64'd0);
    tick();
    @(negedge clk);
    check({tag, ".c1.req_valid"}, {63'd0, mem_req_valid}, 64'd1);
    check({tag, ".c1.req_we"}, {63'd0, mem_req_we}, 64'd0);
    check({tag, ".c1.req_addr"}, {32'd0, mem_req_addr}, {32'd0, a});
    check({tag, ".c1.stall"}, {63'd0, stall}, 64'd1);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = d;
    @(negedge clk);
    check({tag, ".c2.req_valid"}, {63'd0, mem_req_valid}, 64'd0);
    check({tag, ".c2.stall"}, {63'd0, stall}, 64'd1);
    check({tag, ".c2.wb_valid"}, {63'd0, wb_valid}, 64'd0);
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
    @(negedge clk);
    check({tag, ".c3.wb_valid"}, {63'd0, wb_valid}, 64'd1);
    check({tag, ".c3.wb_rd"}, {59'd0, wb_rd}, {59'd0, r});
    check({tag, ".c3.wb_data"}, {32'd0, wb_data}, {32'd0, d});
    check({tag, ".c3.op_done"}, {63'd0, op_done}, 64'd1);
    check({tag, ".c3.op_err"}, {63'd0, op_err}, 64'd0);
    check({tag, ".c3.stall"}, {63'd0, stall}, 64'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;

    // Reset state
    @(negedge clk);
    all_zero("reset");
    #2 rst = 1'b1;
    tick();

    // Best-case load; EX keeps presenting the instruction through DONE
    run_load("load", 32'h40, 5'd5, 32'hDEADBEEF);
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    @(negedge clk);
    check("load.c4.wb_valid", {63'd0, wb_valid}, 64'd0);
    check("load.c4.op_done", {63'd0, op_done}, 64'd0);
    tick();
    @(negedge clk);
    check("load.done_ignores_ex", {63'd0, mem_req_valid}, 64'd0);
    tick();

    // Store with 3 cycles of backpressure
    ex_valid = 1'b1; ex_is_store = 1'b1; ex_is_load = 1'b0;
    ex_addr = 32'h80; ex_wdata = 32'h12345678; ex_rd = 5'd0; mem_req_ready = 1'b0;
    @(negedge clk);
    check("store.c0.stall", {63'd0, stall}, 64'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) mem_req_ready = 1'b1;
      @(negedge clk);
      check("store.req_valid", {63'd0, mem_req_valid}, 64'd1);
      check("store.req_we", {63'd0, mem_req_we}, 64'd1);
      check("store.req_addr", {32'd0, mem_req_addr}, 64'h80);
      check("store.req_wdata", {32'd0, mem_req_wdata}, 64'h12345678);
      check("store.stall", {63'd0, stall}, 64'd1);
    end
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("store.done.op_done", {63'd0, op_done}, 64'd1);
    check("store.done.op_err", {63'd0, op_err}, 64'd0);
    check("store.done.wb_valid", {63'd0, wb_valid}, 64'd0);
    check("store.done.req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("store.done.stall", {63'd0, stall}, 64'd0);
    tick();
    ex_valid = 1'b0; ex_is_store = 1'b0;
    @(negedge clk);
    check("store.after.op_done", {63'd0, op_done}, 64'd0);
    tick();

    // Misaligned load: no request, error retire in cycle 1
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_addr = 32'h42; ex_rd = 5'd6; mem_req_ready = 1'b1;
    @(negedge clk);
    check("misal.c0.stall", {63'd0, stall}, 64'd1);
    check("misal.c0.req_valid", {63'd0, mem_req_valid}, 64'd0);
    tick();
    @(negedge clk);
    check("misal.c1.op_done", {63'd0, op_done}, 64'd1);
    check("misal.c1.op_err", {63'd0, op_err}, 64'd1);
    check("misal.c1.wb_valid", {63'd0, wb_valid}, 64'd0);
    check("misal.c1.req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("misal.c1.stall", {63'd0, stall}, 64'd0);
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    @(negedge clk);
    check("misal.c2.op_done", {63'd0, op_done}, 64'd0);
    check("misal.c2.req_valid", {63'd0, mem_req_valid}, 64'd0);
    tick();

    // Non-memory instruction passes silently
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_addr = 32'h100;
    @(negedge clk);
    check("nonmem.stall", {63'd0, stall}, 64'd0);
    tick();
    ex_valid = 1'b0;
    @(negedge clk);
    check("nonmem.req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("nonmem.op_done", {63'd0, op_done}, 64'd0);
    tick();

    // Load with no response: WAIT spans cycles 2..5
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_addr = 32'h20; ex_rd = 5'd7; mem_req_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    @(negedge clk);
    check("tmo.c5.stall", {63'd0, stall}, 64'd1);
    check("tmo.c5.op_done", {63'd0, op_done}, 64'd0);
    tick();
`ifdef LSU_TIMEOUT_EN
    @(negedge clk);
    check("tmo.c6.op_done", {63'd0, op_done}, 64'd1);
    check("tmo.c6.op_err", {63'd0, op_err}, 64'd1);
    check("tmo.c6.wb_valid", {63'd0, wb_valid}, 64'd0);
    check("tmo.c6.stall", {63'd0, stall}, 64'd0);
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBAD0BAD0;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("tmo.late.wb_valid", {63'd0, wb_valid}, 64'd0);
    check("tmo.late.op_done", {63'd0, op_done}, 64'd0);
    check("tmo.late.req_valid", {63'd0, mem_req_valid}, 64'd0);
`else
    @(negedge clk);
    check("hold.c6.stall", {63'd0, stall}, 64'd1);
    check("hold.c6.op_done", {63'd0, op_done}, 64'd0);
    for (int i = 0; i < 14; i++) tick();
    @(negedge clk);
    check("hold.c20.stall", {63'd0, stall}, 64'd1);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBAD0BAD0;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("hold.rsp.wb_valid", {63'd0, wb_valid}, 64'd1);
    check("hold.rsp.wb_data", {32'd0, wb_data}, 64'hBAD0BAD0);
    check("hold.rsp.wb_rd", {59'd0, wb_rd}, 64'd7);
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
`endif
    tick();

    // Reset while in WAIT, then a fresh load
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_addr = 32'h30; ex_rd = 5'd3; mem_req_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rstwait.in_wait", {63'd0, stall}, 64'd1);
    tick();
    #2;
    rst = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
    #1;
    all_zero("rstwait");
    #2 rst = 1'b1;
    tick();
    @(negedge clk);
    check("rstwait.after.op_done", {63'd0, op_done}, 64'd0);
    check("rstwait.after.req_valid", {63'd0, mem_req_valid}, 64'd0);
    tick();
    run_load("fresh", 32'h44, 5'd9, 32'hCAFEF00D);
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    tick();

    // Back-to-back loads: second accepted in the cycle after DONE
    run_load("b2b0", 32'h10, 5'd1, 32'h11111111);
    tick();
    run_load("b2b1", 32'h14, 5'd2, 32'h22222222);
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    @(negedge clk);
    check("b2b.end.wb_valid", {63'd0, wb_valid}, 64'd0);
    check("b2b.end.stall", {63'd0, stall}, 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
